// File: rtl/fb_row_reader_pkg.sv
// Shared framebuffer helpers: bytes-per-pixel derivation and depth legality.
// Used by both the row reader and the host write path packer.
package fb_row_reader_pkg;

   function automatic int tw_of(input int bitdepth);
      return bitdepth / 8;
   endfunction

   function automatic bit depth_ok(input int bitdepth);
      return (bitdepth == 8) || (bitdepth == 16) || (bitdepth == 24);
   endfunction

endpackage

// File: rtl/fb_row_reader_byte_serializer.sv
// Splits one pixel into TW bytes, LSB first, behind a valid/ready handshake.
// done pulses on the handshake of the final byte of the pixel.
module fb_row_reader_byte_serializer
   import fb_row_reader_pkg::*;
#(
   parameter int BITDEPTH = 24
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                load,
   input  logic [BITDEPTH-1:0] din,
   input  logic                last_col,
   input  logic                out_ready,
   output logic [7:0]          out_data,
   output logic                out_valid,
   output logic                out_last,
   output logic                done
);

   localparam int TW = tw_of(BITDEPTH);
   localparam int IW = (TW > 1) ? $clog2(TW) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(TW - 1);

   logic [BITDEPTH-1:0] sreg;
   logic [IW-1:0]       idx;
   logic                hs;
   logic                last_byte;

   assign hs        = out_valid & out_ready;
   assign last_byte = (idx == LAST_IDX);
   assign done      = hs & last_byte;
   assign out_data  = sreg[7:0];
   assign out_last  = out_valid & last_col & last_byte;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sreg      <= '0;
         idx       <= '0;
         out_valid <= 1'b0;
      end else if (load) begin
         sreg      <= din;
         idx       <= '0;
         out_valid <= 1'b1;
      end else if (hs) begin
         sreg <= sreg >> 8;
         idx  <= idx + 1'b1;
         if (last_byte) out_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/fb_row_reader.sv
// Reads one framebuffer row per command and streams it out as bytes.
// FSM and column counter live here; byte splitting is in the serializer.
module fb_row_reader
   import fb_row_reader_pkg::*;
#(
   parameter int N_ROWS     = 64,
   parameter int N_COLS     = 64,
   parameter int BITDEPTH   = 24,
   parameter int LOG_N_ROWS = $clog2(N_ROWS),
   parameter int LOG_N_COLS = $clog2(N_COLS)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [LOG_N_ROWS-1:0] cmd_row,
   input  logic                  cmd_stb,
   output logic                  busy,
   output logic [LOG_N_ROWS-1:0] fbr_row_addr,
   output logic                  fbr_row_load,
   input  logic                  fbr_row_rdy,
   output logic [LOG_N_COLS-1:0] fbr_col_addr,
   output logic                  fbr_rden,
   input  logic [23:0]           fbr_data,
   output logic [7:0]            out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_last
);

   if (!depth_ok(BITDEPTH)) begin : g_bad_depth
      $error("fb_row_reader: BITDEPTH must be 8, 16 or 24");
   end

   typedef enum logic [2:0] {
      IDLE, LOAD, WAIT_RDY, READ, FETCH, SEND
   } state_t;

   localparam logic [LOG_N_COLS-1:0] LAST_COL = LOG_N_COLS'(N_COLS - 1);

   state_t                state;
   state_t                state_nx;
   logic [LOG_N_COLS-1:0] col;
   logic                  last_col;
   logic                  ser_load;
   logic                  ser_done;

   assign last_col     = (col == LAST_COL);
   assign fbr_col_addr = col;
   assign fbr_rden     = (state == READ);
   assign fbr_row_load = (state == LOAD);

   always_comb begin
      state_nx = state;
      ser_load = 1'b0;
      unique case (state)
         IDLE:     if (cmd_stb) state_nx = LOAD;
         LOAD:     state_nx = WAIT_RDY;
         WAIT_RDY: if (fbr_row_rdy) state_nx = READ;
         READ:     state_nx = FETCH;
         FETCH: begin
            ser_load = 1'b1;
            state_nx = SEND;
         end
         SEND:     if (ser_done) state_nx = last_col ? IDLE : READ;
         default:  state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         busy         <= 1'b0;
         fbr_row_addr <= '0;
         col          <= '0;
      end else begin
         state <= state_nx;
         busy  <= (state_nx != IDLE);
         if (state == IDLE && cmd_stb) begin
            fbr_row_addr <= cmd_row;
            col          <= '0;
         end else if (state == SEND && ser_done && !last_col) begin
            col <= col + 1'b1;
         end
      end
   end

   fb_row_reader_byte_serializer #(
      .BITDEPTH (BITDEPTH)
   ) u_ser (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (ser_load),
      .din       (fbr_data[BITDEPTH-1:0]),
      .last_col  (last_col),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_last  (out_last),
      .done      (ser_done)
   );

endmodule

// File: tb/tb_fb_row_reader.sv
// Directed bench: 24-bit/4-col main DUT plus 16-bit and 8-bit DUTs.
// A small framebuffer model per DUT supplies col-indexed pixel data.
module tb_fb_row_reader;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // DUT A: 24-bit, 4 columns
   logic [2:0]  cmd_row_a = '0;
   logic        cmd_stb_a = 1'b0;
   logic        busy_a, load_a, rden_a, ov_a, ol_a, rdy_a;
   logic [2:0]  row_addr_a;
   logic [1:0]  col_a;
   logic [23:0] data_a = '0;
   logic [7:0]  od_a;
   logic        or_a = 1'b1;
   int          rdy_delay = 0;
   int          rdy_cnt = 0;

   assign rdy_a = (rdy_cnt == 0);
   always @(posedge clk) begin
      if (load_a) rdy_cnt <= rdy_delay;
      else if (rdy_cnt != 0) rdy_cnt <= rdy_cnt - 1;
      if (rden_a) data_a <= 24'h332211 + 24'(col_a);
   end

   fb_row_reader #(.N_ROWS(8), .N_COLS(4), .BITDEPTH(24)) u_a (
      .clk(clk), .rst_n(rst_n), .cmd_row(cmd_row_a), .cmd_stb(cmd_stb_a),
      .busy(busy_a), .fbr_row_addr(row_addr_a), .fbr_row_load(load_a),
      .fbr_row_rdy(rdy_a), .fbr_col_addr(col_a), .fbr_rden(rden_a),
      .fbr_data(data_a), .out_data(od_a), .out_valid(ov_a),
      .out_ready(or_a), .out_last(ol_a)
   );

   // DUT B: 16-bit, 2 columns; DUT C: 8-bit, 3 columns
   logic [2:0]  cmd_row_bc = 3'd1;
   logic        cmd_stb_bc = 1'b0;
   logic        or_bc = 1'b1;
   logic        rdy_bc = 1'b1;
   logic        busy_b, load_b, rden_b, ov_b, ol_b;
   logic        busy_c, load_c, rden_c, ov_c, ol_c;
   logic [2:0]  row_addr_b, row_addr_c;
   logic [0:0]  col_b;
   logic [1:0]  col_c;
   logic [23:0] data_b = '0;
   logic [23:0] data_c = '0;
   logic [7:0]  od_b, od_c;

   always @(posedge clk) begin
      if (rden_b) data_b <= 24'h00BEEF + 24'(col_b);
      if (rden_c) data_c <= 24'h000040 + 24'(col_c);
   end

   fb_row_reader #(.N_ROWS(8), .N_COLS(2), .BITDEPTH(16)) u_b (
      .clk(clk), .rst_n(rst_n), .cmd_row(cmd_row_bc), .cmd_stb(cmd_stb_bc),
      .busy(busy_b), .fbr_row_addr(row_addr_b), .fbr_row_load(load_b),
      .fbr_row_rdy(rdy_bc), .fbr_col_addr(col_b), .fbr_rden(rden_b),
      .fbr_data(data_b), .out_data(od_b), .out_valid(ov_b),
      .out_ready(or_bc), .out_last(ol_b)
   );

   fb_row_reader #(.N_ROWS(8), .N_COLS(3), .BITDEPTH(8)) u_c (
      .clk(clk), .rst_n(rst_n), .cmd_row(cmd_row_bc), .cmd_stb(cmd_stb_bc),
      .busy(busy_c), .fbr_row_addr(row_addr_c), .fbr_row_load(load_c),
      .fbr_row_rdy(rdy_bc), .fbr_col_addr(col_c), .fbr_rden(rden_c),
      .fbr_data(data_c), .out_data(od_c), .out_valid(ov_c),
      .out_ready(or_bc), .out_last(ol_c)
   );

   logic [7:0] bytes_q[$];
   int last_pos, last_cnt, load_cnt, rden_first, valid_first;
   int busy_fall, busy_at1, stab_err;

   function automatic logic [7:0] exp_a(input int i);
      case (i % 3)
         0:       return 8'h11 + 8'(i / 3);
         1:       return 8'h22;
         default: return 8'h33;
      endcase
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // cmd_stb issued in cycle 0; cyc counts cycles after it.
   task automatic run_a(input logic [2:0] row, input int delay,
                        input bit stall, input bit inject);
      logic [7:0] pd;
      logic       pl, pstall;
      bytes_q.delete();
      last_pos = -1; last_cnt = 0; load_cnt = 0; rden_first = -1;
      valid_first = -1; busy_fall = -1; busy_at1 = 0; stab_err = 0;
      pstall = 1'b0; pd = '0; pl = 1'b0;
      rdy_delay = delay;
      cmd_row_a = row;
      cmd_stb_a = 1'b1;
      or_a = 1'b1;
      step();
      cmd_stb_a = 1'b0;
      for (int cyc = 1; cyc < 400 && busy_fall < 0; cyc++) begin
         or_a = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         if (inject) begin
            cmd_stb_a = (cyc == 9);
            cmd_row_a = 3'd5;
         end
         if (cyc == 1) busy_at1 = int'(busy_a);
         if (load_a) load_cnt++;
         if (rden_a && rden_first < 0) rden_first = cyc;
         if (ov_a && valid_first < 0) valid_first = cyc;
         if (!busy_a && busy_fall < 0) busy_fall = cyc;
         if (pstall && (!ov_a || od_a != pd || ol_a != pl)) stab_err++;
         if (ov_a && or_a) begin
            if (ol_a) begin
               last_pos = bytes_q.size();
               last_cnt++;
            end
            bytes_q.push_back(od_a);
         end
         pstall = ov_a && !or_a;
         pd = od_a;
         pl = ol_a;
         step();
      end
      cmd_stb_a = 1'b0;
      or_a = 1'b1;
   endtask

   task automatic check_bytes_a(input string tag);
      check({tag, "_nbytes"}, bytes_q.size(), 12);
      for (int i = 0; i < 12; i++)
         check(tag, (i < bytes_q.size()) ? bytes_q[i] : 8'hxx, exp_a(i));
      check({tag, "_lastpos"}, last_pos, 11);
      check({tag, "_lastcnt"}, last_cnt, 1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      logic [7:0] bq[$];
      logic [7:0] cq[$];
      int b_fall, c_fall, c_vfirst, found;

      step();
      step();
      check("rst_busy", busy_a, 0);
      check("rst_row_addr", row_addr_a, 0);
      check("rst_load", load_a, 0);
      check("rst_col", col_a, 0);
      check("rst_rden", rden_a, 0);
      check("rst_data", od_a, 0);
      check("rst_valid", ov_a, 0);
      check("rst_last", ol_a, 0);
      rst_n = 1'b1;
      step();
      step();

      run_a(3'd3, 0, 1'b0, 1'b0);
      check("t1_busy_rise", busy_at1, 1);
      check("t1_rden_first", rden_first, 3);
      check("t1_valid_first", valid_first, 5);
      check("t1_busy_fall", busy_fall, 23);
      check("t1_loads", load_cnt, 1);
      check("t1_row_addr", row_addr_a, 3);
      check_bytes_a("t1_byte");
      step();

      run_a(3'd1, 10, 1'b0, 1'b0);
      check("t2_rden_first", rden_first, 13);
      check("t2_valid_first", valid_first, 15);
      check("t2_busy_fall", busy_fall, 33);
      check("t2_loads", load_cnt, 1);
      step();

      run_a(3'd2, 0, 1'b1, 1'b0);
      check("t3_stable", stab_err, 0);
      check_bytes_a("t3_byte");
      step();

      run_a(3'd6, 0, 1'b0, 1'b1);
      check("t4_row_addr", row_addr_a, 6);
      check("t4_loads", load_cnt, 1);
      check("t4_busy_fall", busy_fall, 23);
      check_bytes_a("t4_byte");
      step();

      cmd_row_a = 3'd4;
      cmd_stb_a = 1'b1;
      step();
      cmd_stb_a = 1'b0;
      found = 0;
      for (int i = 0; i < 100 && found == 0; i++) begin
         if (ov_a && col_a == 2'd2) found = 1;
         else step();
      end
      check("t5_reached_col2", found, 1);
      rst_n = 1'b0;
      #1;
      check("t5_busy", busy_a, 0);
      check("t5_row_addr", row_addr_a, 0);
      check("t5_load", load_a, 0);
      check("t5_col", col_a, 0);
      check("t5_rden", rden_a, 0);
      check("t5_data", od_a, 0);
      check("t5_valid", ov_a, 0);
      check("t5_last", ol_a, 0);
      step();
      rst_n = 1'b1;
      step();
      run_a(3'd0, 0, 1'b0, 1'b0);
      check("t5_rden_first", rden_first, 3);
      check("t5_busy_fall", busy_fall, 23);
      check_bytes_a("t5_byte");

      b_fall = -1; c_fall = -1; c_vfirst = -1;
      cmd_stb_bc = 1'b1;
      step();
      cmd_stb_bc = 1'b0;
      for (int cyc = 1; cyc < 40; cyc++) begin
         if (ov_b) bq.push_back(od_b);
         if (ov_c) cq.push_back(od_c);
         if (ov_c && c_vfirst < 0) c_vfirst = cyc;
         if (!busy_b && b_fall < 0) b_fall = cyc;
         if (!busy_c && c_fall < 0) c_fall = cyc;
         if (ov_c && ol_c) check("c_last_byte", od_c, 8'h42);
         step();
      end
      check("b_nbytes", bq.size(), 4);
      check("b_byte0", (bq.size() > 0) ? bq[0] : 8'hxx, 8'hEF);
      check("b_byte1", (bq.size() > 1) ? bq[1] : 8'hxx, 8'hBE);
      check("b_byte2", (bq.size() > 2) ? bq[2] : 8'hxx, 8'hF0);
      check("b_byte3", (bq.size() > 3) ? bq[3] : 8'hxx, 8'hBE);
      check("b_busy_fall", b_fall, 11);
      check("c_nbytes", cq.size(), 3);
      check("c_byte0", (cq.size() > 0) ? cq[0] : 8'hxx, 8'h40);
      check("c_byte1", (cq.size() > 1) ? cq[1] : 8'hxx, 8'h41);
      check("c_byte2", (cq.size() > 2) ? cq[2] : 8'hxx, 8'h42);
      check("c_valid_first", c_vfirst, 5);
      check("c_busy_fall", c_fall, 12);
      check("c_row_addr", row_addr_c, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
